// File: rtl/tdm_demux_pkg.sv
// Shared types and constants for the tdm_demux4 receive demultiplexer.
package tdm_demux_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } sync_state_t;

    localparam int NUM_LANES = 4;
    localparam int MISS_W    = 3;

    typedef logic [1:0]        slot_t;
    typedef logic [MISS_W-1:0] miss_t;

endpackage

// File: rtl/tdm_sync_fsm.sv
// Frame alignment tracker: decides which lane each valid beat belongs to,
// whether it is delivered, and whether it closes a cleanly aligned frame.
module tdm_sync_fsm
    import tdm_demux_pkg::*;
#(
    parameter int MISS_LIMIT = 2
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  din_valid,
    input  logic  frame_sync,
    output slot_t route_slot,
    output logic  deliver,
    output logic  frame_ok,
    output logic  locked,
    output logic  sync_err
);

    localparam miss_t MISS_MAX = miss_t'(MISS_LIMIT);

    sync_state_t state_q, state_d;
    slot_t       slot_q, slot_d;
    miss_t       miss_q, miss_d;
    logic        aligned_q, aligned_d;
    logic        err_d;
    miss_t       miss_inc;

    assign miss_inc = miss_q + miss_t'(1);

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        miss_d     = miss_q;
        aligned_d  = aligned_q;
        err_d      = 1'b0;
        deliver    = 1'b0;
        route_slot = slot_q;
        frame_ok   = 1'b0;
        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    if (frame_sync) begin
                        deliver    = 1'b1;
                        route_slot = '0;
                        slot_d     = slot_t'(1);
                        state_d    = LOCKED;
                        miss_d     = '0;
                        aligned_d  = 1'b1;
                    end
                end
                LOCKED: begin
                    deliver = 1'b1;
                    if (slot_q == '0 || frame_sync) begin
                        // Every frame-start beat (expected or forced by an early sync) lands on lane 0
                        route_slot = '0;
                        slot_d     = slot_t'(1);
                        if (frame_sync && slot_q == '0) begin
                            miss_d    = '0;
                            aligned_d = 1'b1;
                        end else if (frame_sync) begin
                            err_d     = 1'b1;
                            miss_d    = '0;
                            aligned_d = 1'b0;
                        end else begin
                            err_d     = 1'b1;
                            aligned_d = 1'b0;
                            miss_d    = miss_inc;
                            if (miss_inc >= MISS_MAX) begin
                                state_d = HUNT;
                                slot_d  = '0;
                                miss_d  = '0;
                            end
                        end
                    end else begin
                        route_slot = slot_q;
                        slot_d     = slot_q + slot_t'(1);
                        frame_ok   = (slot_q == slot_t'(NUM_LANES - 1)) && aligned_q;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= HUNT;
            slot_q    <= '0;
            miss_q    <= '0;
            aligned_q <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            miss_q    <= miss_d;
            aligned_q <= aligned_d;
            sync_err  <= err_d;
        end
    end

    assign locked = (state_q == LOCKED);

endmodule

// File: rtl/tdm_demux4.sv
// Four-lane TDM receive demultiplexer with frame alignment tracking.
// Optional statistics counters are enabled with TDM_DEMUX_STATS_EN.
module tdm_demux4
    import tdm_demux_pkg::*;
#(
    parameter int WIDTH      = 1,
    parameter int MISS_LIMIT = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           din,
    input  logic                       din_valid,
    input  logic                       frame_sync,
    output logic [NUM_LANES*WIDTH-1:0] lane_data,
    output logic [NUM_LANES-1:0]       lane_valid,
    output logic                       frame_done,
    output logic                       locked,
    output logic                       sync_err
`ifdef TDM_DEMUX_STATS_EN
    ,
    output logic [15:0]                frame_cnt,
    output logic [7:0]                 err_cnt
`endif
);

    slot_t route;
    logic  deliver;
    logic  frame_ok;

    tdm_sync_fsm #(
        .MISS_LIMIT (MISS_LIMIT)
    ) u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .route_slot (route),
        .deliver    (deliver),
        .frame_ok   (frame_ok),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_data  <= '0;
            lane_valid <= '0;
            frame_done <= 1'b0;
        end else begin
            lane_valid <= '0;
            frame_done <= 1'b0;
            if (deliver) begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    if (route == slot_t'(i)) begin
                        lane_data[i*WIDTH +: WIDTH] <= din;
                        lane_valid[i]               <= 1'b1;
                    end
                end
                frame_done <= frame_ok;
            end
        end
    end

`ifdef TDM_DEMUX_STATS_EN
    // Counters follow the registered pulses, so they settle one cycle after them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (frame_done && frame_cnt != '1) frame_cnt <= frame_cnt + 16'd1;
            if (sync_err && err_cnt != '1)     err_cnt   <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4: directed scenarios plus randomized
// stream compared every cycle against a frame-level behavioural model.
module tb_tdm_demux4;

    localparam int W     = 1;
    localparam int LIMIT = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [W-1:0]   din;
    logic           din_valid;
    logic           frame_sync;
    logic [4*W-1:0] lane_data;
    logic [3:0]     lane_valid;
    logic           frame_done;
    logic           locked;
    logic           sync_err;
`ifdef TDM_DEMUX_STATS_EN
    logic [15:0]    frame_cnt;
    logic [7:0]     err_cnt;
    int             m_fc = 0;
    int             m_ec = 0;
`endif

    int errors = 0;
    int checks = 0;

    tdm_demux4 #(.WIDTH(W), .MISS_LIMIT(LIMIT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .lane_data  (lane_data),
        .lane_valid (lane_valid),
        .frame_done (frame_done),
        .locked     (locked),
        .sync_err   (sync_err)
`ifdef TDM_DEMUX_STATS_EN
        ,
        .frame_cnt  (frame_cnt),
        .err_cnt    (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0][W-1:0] lane;
        logic [3:0]        lv;
        logic              fd;
        logic              err;
        logic              lk;
        int                pos;
        int                miss;
        logic              good;
    } mstate_t;

    mstate_t m_q = '0;

    // Frame-level reference: position within the frame, miss tally, frame health.
    function automatic mstate_t step(mstate_t m, logic [W-1:0] d, logic dv, logic fs);
        mstate_t n = m;
        n.lv  = '0;
        n.fd  = 1'b0;
        n.err = 1'b0;
        if (!dv) return n;
        if (!m.lk) begin
            if (fs) begin
                n.lane[0] = d; n.lv = 4'b0001; n.lk = 1'b1;
                n.pos = 1; n.miss = 0; n.good = 1'b1;
            end
        end else if (fs || m.pos == 0) begin
            n.lane[0] = d; n.lv = 4'b0001; n.pos = 1;
            if (fs && m.pos == 0) begin
                n.miss = 0; n.good = 1'b1;
            end else if (fs) begin
                n.err = 1'b1; n.miss = 0; n.good = 1'b0;
            end else begin
                n.err = 1'b1; n.good = 1'b0; n.miss = m.miss + 1;
                if (n.miss >= LIMIT) begin
                    n.lk = 1'b0; n.pos = 0; n.miss = 0;
                end
            end
        end else begin
            n.lane[m.pos[1:0]] = d;
            n.lv[m.pos[1:0]]   = 1'b1;
            if (m.pos == 3) n.fd = m.good;
            n.pos = (m.pos + 1) % 4;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_q <= '0;
        else        m_q <= step(m_q, din, din_valid, frame_sync);
    end

`ifdef TDM_DEMUX_STATS_EN
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_fc <= 0;
            m_ec <= 0;
        end else begin
            if (m_q.fd && m_fc < 65535) m_fc <= m_fc + 1;
            if (m_q.err && m_ec < 255)  m_ec <= m_ec + 1;
        end
    end
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("lane_data",  32'(lane_data),  32'(m_q.lane));
        check("lane_valid", 32'(lane_valid), 32'(m_q.lv));
        check("frame_done", 32'(frame_done), 32'(m_q.fd));
        check("locked",     32'(locked),     32'(m_q.lk));
        check("sync_err",   32'(sync_err),   32'(m_q.err));
        check("lv_onehot",  32'($countones(lane_valid) <= 1), 32'd1);
    end

    task automatic send(input logic [W-1:0] d, input logic fs);
        @(negedge clk);
        din = d; din_valid = 1'b1; frame_sync = fs;
    endtask

    task automatic settle();
        @(negedge clk);
        din_valid = 1'b0; frame_sync = 1'b0; din = '0;
    endtask

    int tx_slot;
    int r;

    initial begin
        rst_n = 1'b0; din = '0; din_valid = 1'b0; frame_sync = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Hunt: beats without frame_sync are discarded
        for (int i = 0; i < 5; i++) send(W'(i & 1), 1'b0);
        settle();
        check("hunt_lanes",  32'(lane_data), 32'h0);
        check("hunt_locked", 32'(locked),    32'h0);

        // Clean frame 1,0,1,1 -> 4'b1101
        send(1, 1); send(0, 0); send(1, 0); send(1, 0);
        settle();
        check("clean_lanes", 32'(lane_data),  32'hD);
        check("clean_lv",    32'(lane_valid), 32'h8);
        check("clean_fd",    32'(frame_done), 32'h1);
        check("clean_lock",  32'(locked),     32'h1);

        // Gap of three idle cycles between slots 1 and 2
        send(0, 1); send(1, 0);
        repeat (3) settle();
        send(0, 0); send(0, 0);
        settle();
        check("gap_lanes", 32'(lane_data),  32'h2);
        check("gap_fd",    32'(frame_done), 32'h1);

        // Early sync at slot 2
        send(1, 1); send(0, 0); send(1, 1);
        settle();
        check("early_err",   32'(sync_err),   32'h1);
        check("early_lv",    32'(lane_valid), 32'h1);
        send(1, 0); send(0, 0); send(1, 0);
        settle();
        check("early_lanes", 32'(lane_data),  32'hB);
        check("early_nofd",  32'(frame_done), 32'h0);
        send(0, 1); send(0, 0); send(0, 0); send(0, 0);
        settle();
        check("after_fd",    32'(frame_done), 32'h1);

        // Loss of lock after two missing syncs
        send(1, 0);
        settle();
        check("miss1_err",  32'(sync_err), 32'h1);
        check("miss1_lock", 32'(locked),   32'h1);
        send(0, 0); send(0, 0); send(0, 0);
        send(0, 0);
        settle();
        check("miss2_err",  32'(sync_err), 32'h1);
        check("miss2_lock", 32'(locked),   32'h0);
        send(1, 0); send(1, 0); send(1, 0);
        settle();
        check("discard_lanes", 32'(lane_data), 32'h0);
        send(1, 1);
        settle();
        check("relock", 32'(locked), 32'h1);

        // Async reset mid-frame at slot 2, between clock edges
        send(1, 0);
        settle();
        #2 rst_n = 1'b0;
        #1;
        check("arst_lanes", 32'(lane_data),  32'h0);
        check("arst_lock",  32'(locked),     32'h0);
        check("arst_lv",    32'(lane_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        send(1, 0);
        settle();
        check("arst_hunt", 32'(lane_valid), 32'h0);

        // Randomized stream with mostly-correct framing
        tx_slot = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            din_valid = ($urandom % 4) != 0;
            din = W'($urandom);
            r = int'($urandom % 100);
            frame_sync = din_valid && ((tx_slot == 0) ? (r < 88) : (r < 4));
            if (din_valid) tx_slot = (tx_slot + 1) % 4;
        end
        repeat (3) settle();
`ifdef TDM_DEMUX_STATS_EN
        check("frame_cnt", 32'(frame_cnt), 32'(m_fc));
        check("err_cnt",   32'(err_cnt),   32'(m_ec));
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
